thread_scheduler: RTL and testbench

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/thread_scheduler_pkg.sv | 19 +
 rtl/thread_scheduler_rr_arb2.sv | 21 ++
 rtl/thread_scheduler.sv | 99 +++++++++
 tb/tb_thread_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_scheduler_pkg.sv
// Shared widths, reset-PC defaults and small helpers for the two-thread issue scheduler.
package thread_scheduler_pkg;
   localparam int WORD     = 16;
   localparam int PRE      = 4;
   localparam int TID      = 1;
   localparam int NTHREADS = 2;

   localparam logic [WORD-1:0] T0_START_DEFAULT = 16'h0000;
   localparam logic [WORD-1:0] T1_START_DEFAULT = 16'h0001;

   typedef logic [WORD-1:0] word_t;
   typedef logic [PRE-1:0]  pre_t;
   typedef logic [TID-1:0]  tid_t;

   // Sequential fetch; 16'hFFFF wraps naturally to 16'h0000.
   function automatic word_t pc_inc(input word_t pc);
      return pc + word_t'(1);
   endfunction
endpackage

// File: rtl/thread_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter: the requester that did not win last time is preferred.
module rr_arb2
   import thread_scheduler_pkg::*;
(
   input  logic [1:0] req,
   input  tid_t       last,
   output logic       grant_valid,
   output tid_t       grant_id
);
   tid_t other;

   assign other = ~last;

   always_comb begin
      grant_valid = |req;
      grant_id    = last;
      if (req[other]) begin
         grant_id = other;
      end
   end
endmodule

// File: rtl/thread_scheduler.sv
// Two-thread fetch scheduler: per-thread PC/prefix/halt state, round-robin issue,
// redirect, prefix latching and sticky halt handling.
module thread_scheduler
   import thread_scheduler_pkg::*;
#(
   parameter logic [15:0] T0_START = T0_START_DEFAULT,
   parameter logic [15:0] T1_START = T1_START_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  stall,
   input  logic        issue_ready,
   output logic        issue_valid,
   output logic        issue_tid,
   output logic [15:0] issue_pc,
   output logic [3:0]  issue_pre,
   output logic        issue_pre_valid,
   input  logic        redirect_valid,
   input  logic        redirect_tid,
   input  logic [15:0] redirect_pc,
   input  logic        pre_valid,
   input  logic        pre_tid,
   input  logic [3:0]  pre_val,
   input  logic        halt_req,
   input  logic        halt_tid,
   output logic [1:0]  thread_halted,
   output logic        halted
);
   word_t           pc_reg  [NTHREADS];
   pre_t            pre_reg [NTHREADS];
   logic [1:0]      pre_v_reg;
   logic [1:0]      halted_reg;
   logic            all_halted_reg;
   tid_t            last_reg;
   logic [1:0]      eligible;
   tid_t            grant_id;
   logic            fire;

   // A thread being redirected or halted this cycle must not issue a stale address.
   generate
      for (genvar gi = 0; gi < NTHREADS; gi++) begin : g_elig
         assign eligible[gi] = !halted_reg[gi] && !stall[gi]
                            && !(redirect_valid && redirect_tid == tid_t'(gi))
                            && !(halt_req && halt_tid == tid_t'(gi));
      end
   endgenerate

   rr_arb2 u_arb (
      .req         (eligible),
      .last        (last_reg),
      .grant_valid (issue_valid),
      .grant_id    (grant_id)
   );

   assign issue_tid       = grant_id;
   assign issue_pc        = pc_reg[grant_id];
   assign issue_pre_valid = pre_v_reg[grant_id];
   assign issue_pre       = pre_v_reg[grant_id] ? pre_reg[grant_id] : '0;
   assign fire            = issue_valid && issue_ready;
   assign thread_halted   = halted_reg;
   assign halted          = all_halted_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg[0]      <= T0_START;
         pc_reg[1]      <= T1_START;
         pre_reg[0]     <= '0;
         pre_reg[1]     <= '0;
         pre_v_reg      <= '0;
         halted_reg     <= '0;
         all_halted_reg <= 1'b0;
         last_reg       <= 1'b1;
      end else begin
         for (int t = 0; t < NTHREADS; t++) begin
            if (halt_req && halt_tid == tid_t'(t)) begin
               halted_reg[t] <= 1'b1;
            end else begin
               if (redirect_valid && redirect_tid == tid_t'(t)) begin
                  pc_reg[t] <= redirect_pc;
               end else if (fire && grant_id == tid_t'(t)) begin
                  pc_reg[t] <= pc_inc(pc_reg[t]);
               end
               // A newly decoded prefix outranks any clear from issue or redirect.
               if (pre_valid && pre_tid == tid_t'(t)) begin
                  pre_reg[t]   <= pre_val;
                  pre_v_reg[t] <= 1'b1;
               end else if ((redirect_valid && redirect_tid == tid_t'(t))
                         || (fire && grant_id == tid_t'(t))) begin
                  pre_v_reg[t] <= 1'b0;
               end
            end
         end
         if (fire) begin
            last_reg <= grant_id;
         end
         all_halted_reg <= &halted_reg;
      end
   end
endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic,
// all compared cycle by cycle against a behavioural model of the scheduler.
module tb_thread_scheduler;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  stall;
   logic        issue_ready;
   logic        issue_valid;
   logic        issue_tid;
   logic [15:0] issue_pc;
   logic [3:0]  issue_pre;
   logic        issue_pre_valid;
   logic        redirect_valid;
   logic        redirect_tid;
   logic [15:0] redirect_pc;
   logic        pre_valid;
   logic        pre_tid;
   logic [3:0]  pre_val;
   logic        halt_req;
   logic        halt_tid;
   logic [1:0]  thread_halted;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   thread_scheduler dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .issue_ready     (issue_ready),
      .issue_valid     (issue_valid),
      .issue_tid       (issue_tid),
      .issue_pc        (issue_pc),
      .issue_pre       (issue_pre),
      .issue_pre_valid (issue_pre_valid),
      .redirect_valid  (redirect_valid),
      .redirect_tid    (redirect_tid),
      .redirect_pc     (redirect_pc),
      .pre_valid       (pre_valid),
      .pre_tid         (pre_tid),
      .pre_val         (pre_val),
      .halt_req        (halt_req),
      .halt_tid        (halt_tid),
      .thread_halted   (thread_halted),
      .halted          (halted)
   );

   // Behavioural model state
   logic [15:0] m_pc  [2];
   logic [3:0]  m_pre [2];
   logic        m_pv  [2];
   logic        m_hl  [2];
   logic        m_last;
   logic        m_all;
   // Expected issue for the current cycle
   logic        e_valid;
   logic        e_tid;
   // Snapshot of DUT outputs for literal checks
   logic        s_valid, s_tid, s_prev, s_h;
   logic [15:0] s_pc;
   logic [3:0]  s_pre;
   logic [1:0]  s_th;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc[0] = 16'h0000; m_pc[1] = 16'h0001;
      m_pre[0] = 4'h0;    m_pre[1] = 4'h0;
      m_pv[0] = 1'b0;     m_pv[1] = 1'b0;
      m_hl[0] = 1'b0;     m_hl[1] = 1'b0;
      m_last = 1'b1;
      m_all  = 1'b0;
   endtask

   function automatic logic blocked(input int t);
      return m_hl[t] || stall[t] || (redirect_valid && int'(redirect_tid) == t)
          || (halt_req && int'(halt_tid) == t);
   endfunction

   // Prefer the thread that did not issue last; fall back to the other one.
   task automatic compute_expect();
      int pref;
      pref = m_last ? 0 : 1;
      e_valid = 1'b0;
      e_tid   = 1'b0;
      if (!blocked(pref)) begin
         e_valid = 1'b1; e_tid = pref[0];
      end else if (!blocked(1 - pref)) begin
         e_valid = 1'b1; e_tid = ~pref[0];
      end
   endtask

   task automatic compare_and_snap();
      compute_expect();
      s_valid = issue_valid; s_tid = issue_tid; s_pc = issue_pc;
      s_pre = issue_pre; s_prev = issue_pre_valid; s_th = thread_halted; s_h = halted;
      chk("issue_valid", issue_valid, e_valid);
      if (e_valid && issue_valid) begin
         chk("issue_tid", issue_tid, e_tid);
         chk("issue_pc", issue_pc, m_pc[e_tid]);
         chk("issue_pre_valid", issue_pre_valid, m_pv[e_tid]);
         chk("issue_pre", issue_pre, m_pv[e_tid] ? m_pre[e_tid] : 4'h0);
      end
      chk("thread_halted", thread_halted, {m_hl[1], m_hl[0]});
      chk("halted", halted, m_all);
   endtask

   task automatic model_update();
      logic fire;
      logic all_next;
      fire = e_valid && issue_ready;
      all_next = m_hl[0] && m_hl[1];
      for (int t = 0; t < 2; t++) begin
         logic me_fire, me_redir, me_pre;
         me_fire  = fire && int'(e_tid) == t;
         me_redir = redirect_valid && int'(redirect_tid) == t;
         me_pre   = pre_valid && int'(pre_tid) == t;
         if (halt_req && int'(halt_tid) == t) begin
            m_hl[t] = 1'b1;
         end else begin
            if (me_fire)  m_pc[t] = m_pc[t] + 16'd1;
            if (me_redir) m_pc[t] = redirect_pc;
            if (me_fire || me_redir) m_pv[t] = 1'b0;
            if (me_pre) begin
               m_pre[t] = pre_val;
               m_pv[t]  = 1'b1;
            end
         end
      end
      if (fire) m_last = e_tid;
      m_all = all_next;
   endtask

   task automatic step(input logic [1:0] st, input logic rdy,
                       input logic rv, input logic rt, input logic [15:0] rpc,
                       input logic pv, input logic pt, input logic [3:0] pval,
                       input logic hr, input logic ht);
      @(negedge clk);
      stall = st; issue_ready = rdy;
      redirect_valid = rv; redirect_tid = rt; redirect_pc = rpc;
      pre_valid = pv; pre_tid = pt; pre_val = pval;
      halt_req = hr; halt_tid = ht;
      #1;
      compare_and_snap();
      @(posedge clk);
      model_update();
   endtask

   task automatic go(input logic [1:0] st, input logic rdy);
      step(st, rdy, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic lit_issue(input string name, input logic tid, input logic [15:0] pc);
      chk({name, "_valid"}, s_valid, 1'b1);
      chk({name, "_tid"}, s_tid, tid);
      chk({name, "_pc"}, s_pc, pc);
   endtask

   // Asynchronous reset asserted away from any clock edge; outputs checked while held.
   task automatic do_reset();
      @(negedge clk);
      #2;
      stall = 2'b00; issue_ready = 1'b0;
      redirect_valid = 1'b0; redirect_tid = 1'b0; redirect_pc = 16'h0;
      pre_valid = 1'b0; pre_tid = 1'b0; pre_val = 4'h0;
      halt_req = 1'b0; halt_tid = 1'b0;
      reset = 1'b0;
      model_reset();
      #1;
      compare_and_snap();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      do_reset();
      chk("rst_valid", s_valid, 1'b1);
      chk("rst_tid", s_tid, 1'b0);
      chk("rst_pc", s_pc, 16'h0000);
      chk("rst_halted", {s_th, s_h}, 3'b000);

      // Plain alternation from reset
      go(2'b00, 1'b1); lit_issue("rr0", 1'b0, 16'h0000);
      go(2'b00, 1'b1); lit_issue("rr1", 1'b1, 16'h0001);
      go(2'b00, 1'b1); lit_issue("rr2", 1'b0, 16'h0001);
      go(2'b00, 1'b1); lit_issue("rr3", 1'b1, 16'h0002);

      // Thread 0 stalled: thread 1 issues back to back
      do_reset();
      go(2'b01, 1'b1); lit_issue("st0", 1'b1, 16'h0001);
      go(2'b01, 1'b1); lit_issue("st1", 1'b1, 16'h0002);
      go(2'b01, 1'b1); lit_issue("st2", 1'b1, 16'h0003);
      go(2'b00, 1'b1); lit_issue("st_hold", 1'b0, 16'h0000);

      // Redirect suppresses the offered thread
      do_reset();
      step(2'b00, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      lit_issue("redir_other", 1'b1, 16'h0001);
      go(2'b00, 1'b1); lit_issue("redir_target", 1'b0, 16'h1234);

      // Prefix latch and clear on use
      do_reset();
      step(2'b00, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
      go(2'b00, 1'b1); lit_issue("pre_use", 1'b1, 16'h0001);
      chk("pre_use_val", s_pre, 4'hA);
      chk("pre_use_v", s_prev, 1'b1);
      go(2'b00, 1'b1);
      go(2'b00, 1'b1); lit_issue("pre_next", 1'b1, 16'h0002);
      chk("pre_next_v", s_prev, 1'b0);
      chk("pre_next_val", s_pre, 4'h0);

      // PC wrap
      do_reset();
      step(2'b00, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      go(2'b00, 1'b1); lit_issue("wrap_top", 1'b0, 16'hFFFF);
      go(2'b00, 1'b1);
      go(2'b00, 1'b1); lit_issue("wrap_zero", 1'b0, 16'h0000);

      // Halts, then reset mid-run
      do_reset();
      step(2'b00, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      lit_issue("halt_a", 1'b1, 16'h0001);
      go(2'b00, 1'b1); lit_issue("halt_b", 1'b1, 16'h0002);
      chk("halt_flags1", s_th, 2'b01);
      go(2'b00, 1'b1); lit_issue("halt_c", 1'b1, 16'h0003);
      step(2'b00, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
      chk("halt_none", s_valid, 1'b0);
      go(2'b00, 1'b1);
      chk("halt_flags2", s_th, 2'b11);
      chk("halt_all_late", s_h, 1'b0);
      go(2'b00, 1'b1);
      chk("halt_all", s_h, 1'b1);
      do_reset();
      chk("midrst_valid", s_valid, 1'b1);
      chk("midrst_tid", s_tid, 1'b0);
      chk("midrst_pc", s_pc, 16'h0000);
      chk("midrst_flags", {s_th, s_h}, 3'b000);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic [15:0] rpc;
         if (i % 160 == 0) do_reset();
         rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         step(($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 6) == 0, 1'($urandom), rpc,
              $urandom_range(0, 4) == 0, 1'($urandom), 4'($urandom),
              $urandom_range(0, 60) == 0, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
